// File: rtl/audio_pll_lock_supervisor_if.sv
// Control/status bundle between the audio PLL lock supervisor and its surroundings.
// master: the supervisor side; slave: the PLL/downstream side.
interface audio_pll_lock_supervisor_if;
   logic       pll_locked;
   logic       relock_req;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fault;
   logic [2:0] retry_count;
   logic [7:0] lock_loss_cnt;

   modport master (
      input  pll_locked, relock_req,
      output pll_rst, sys_rst, ready, fault, retry_count, lock_loss_cnt
   );

   modport slave (
      output pll_locked, relock_req,
      input  pll_rst, sys_rst, ready, fault, retry_count, lock_loss_cnt
   );
endinterface

// File: rtl/audio_pll_lock_supervisor.sv
// Audio PLL lock supervisor: drives PLL reset, qualifies lock, releases sys_rst, retries then faults.
// Optional feature: define LOCK_LOSS_CNT_EN to build the saturating lock-loss counter.
module audio_pll_lock_supervisor #(
   parameter int PLL_RST_CYCLES      = 500,
   parameter int LOCK_STABLE_CYCLES  = 50000,
   parameter int LOCK_TIMEOUT_CYCLES = 500000,
   parameter int RETRY_MAX           = 7,
   parameter int CNT_W               = 20
) (
   input  logic                          refclk,
   input  logic                          rst,
   audio_pll_lock_supervisor_if.master   bus
);

   typedef enum logic [2:0] {
      S_PLL_RESET,
      S_WAIT_LOCK,
      S_QUALIFY,
      S_RUN,
      S_FAULT
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [2:0]       RETRY_LIM = 3'(RETRY_MAX);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             sync_p0, sync_p1;
   logic             lock_s;
   logic             do_retry;
   logic             pll_rst_r, sys_rst_r, ready_r, fault_r;
   logic [2:0]       retry_r;

   // Stage boundary: raw asynchronous lock flag into the refclk domain
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= bus.pll_locked;
         sync_p1 <= sync_p0;
      end
   end

   assign lock_s = sync_p1;

   // A lock attempt fails on timeout in WAIT_LOCK (lock wins on the same cycle) or any drop in QUALIFY
   assign do_retry = ((state == S_WAIT_LOCK) && !lock_s && (cnt == TMO_LAST)) ||
                     ((state == S_QUALIFY) && !lock_s);

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state     <= S_PLL_RESET;
         cnt       <= '0;
         pll_rst_r <= 1'b1;
         sys_rst_r <= 1'b1;
         ready_r   <= 1'b0;
         fault_r   <= 1'b0;
         retry_r   <= '0;
      end else if (do_retry) begin
         cnt       <= '0;
         pll_rst_r <= 1'b1;
         if (retry_r == RETRY_LIM) begin
            state   <= S_FAULT;
            fault_r <= 1'b1;
         end else begin
            state   <= S_PLL_RESET;
            retry_r <= retry_r + 3'd1;
         end
      end else begin
         unique case (state)
            S_PLL_RESET: begin
               if (cnt == RST_LAST) begin
                  state     <= S_WAIT_LOCK;
                  cnt       <= '0;
                  pll_rst_r <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_WAIT_LOCK: begin
               if (lock_s) begin
                  state <= S_QUALIFY;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_QUALIFY: begin
               if (cnt == STB_LAST) begin
                  state     <= S_RUN;
                  cnt       <= '0;
                  sys_rst_r <= 1'b0;
                  ready_r   <= 1'b1;
                  retry_r   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_RUN: begin
               if (!lock_s || bus.relock_req) begin
                  state     <= S_PLL_RESET;
                  cnt       <= '0;
                  pll_rst_r <= 1'b1;
                  sys_rst_r <= 1'b1;
                  ready_r   <= 1'b0;
               end
            end
            S_FAULT: begin
               if (bus.relock_req) begin
                  state   <= S_PLL_RESET;
                  cnt     <= '0;
                  fault_r <= 1'b0;
                  retry_r <= '0;
               end
            end
            default: begin
               state     <= S_PLL_RESET;
               cnt       <= '0;
               pll_rst_r <= 1'b1;
               sys_rst_r <= 1'b1;
               ready_r   <= 1'b0;
               fault_r   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pll_rst     = pll_rst_r;
   assign bus.sys_rst     = sys_rst_r;
   assign bus.ready       = ready_r;
   assign bus.fault       = fault_r;
   assign bus.retry_count = retry_r;

`ifdef LOCK_LOSS_CNT_EN
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [7:0] loss_cnt;

   // Only lock drops in RUN count; relock requests leave it untouched
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         loss_cnt <= '0;
      end else if ((state == S_RUN) && !lock_s) begin
         loss_cnt <= sat_inc8(loss_cnt);
      end
   end

   assign bus.lock_loss_cnt = loss_cnt;
`else
   assign bus.lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_audio_pll_lock_supervisor.sv
// Self-checking bench for audio_pll_lock_supervisor: vector table, corner sequences, random traffic vs. phase model.
module tb_audio_pll_lock_supervisor;
   localparam int PRC  = 4;
   localparam int LSC  = 8;
   localparam int LTC  = 20;
   localparam int RMAX = 2;
`ifdef LOCK_LOSS_CNT_EN
   localparam int LL_ON = 1;
`else
   localparam int LL_ON = 0;
`endif

   logic refclk = 1'b0;
   logic rst    = 1'b1;
   audio_pll_lock_supervisor_if bus();

   audio_pll_lock_supervisor #(
      .PLL_RST_CYCLES     (PRC),
      .LOCK_STABLE_CYCLES (LSC),
      .LOCK_TIMEOUT_CYCLES(LTC),
      .RETRY_MAX          (RMAX),
      .CNT_W              (20)
   ) dut (
      .refclk(refclk),
      .rst   (rst),
      .bus   (bus)
   );

   always #5 refclk = ~refclk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: phases with elapsed-edge arithmetic and a two-deep sample queue for sync delay
   localparam int M_RST = 0, M_WAIT = 1, M_QUAL = 2, M_RUN = 3, M_FAULT = 4;
   int m_phase, m_ecnt, m_pstart, m_retries, m_losses, m_el;
   bit m_q[$];
   bit m_ls;

   task automatic m_go(input int ph);
      m_phase  = ph;
      m_pstart = m_ecnt;
   endtask

   task automatic m_retry();
      if (m_retries == RMAX) m_go(M_FAULT);
      else begin
         m_retries++;
         m_go(M_RST);
      end
   endtask

   always @(posedge refclk or posedge rst) begin
      if (rst) begin
         m_phase = M_RST; m_ecnt = 0; m_pstart = 0; m_retries = 0; m_losses = 0;
         m_q.delete();
      end else begin
         m_ls = (m_q.size() >= 2) ? m_q[0] : 1'b0;
         m_q.push_back(bus.pll_locked);
         if (m_q.size() > 2) void'(m_q.pop_front());
         m_ecnt++;
         m_el = m_ecnt - m_pstart;
         case (m_phase)
            M_RST:   if (m_el == PRC) m_go(M_WAIT);
            M_WAIT:  if (m_ls) m_go(M_QUAL); else if (m_el == LTC) m_retry();
            M_QUAL:  if (!m_ls) m_retry(); else if (m_el == LSC) begin m_retries = 0; m_go(M_RUN); end
            M_RUN:   if (!m_ls) begin if (m_losses < 255) m_losses++; m_go(M_RST); end
                     else if (bus.relock_req) m_go(M_RST);
            M_FAULT: if (bus.relock_req) begin m_retries = 0; m_go(M_RST); end
            default: m_go(M_RST);
         endcase
      end
   end

   always @(negedge refclk) begin
      if (!rst) begin
         chk("model.pll_rst", 32'(bus.pll_rst), 32'(m_phase == M_RST || m_phase == M_FAULT));
         chk("model.sys_rst", 32'(bus.sys_rst), 32'(m_phase != M_RUN));
         chk("model.ready",   32'(bus.ready),   32'(m_phase == M_RUN));
         chk("model.fault",   32'(bus.fault),   32'(m_phase == M_FAULT));
         chk("model.retry_count",   32'(bus.retry_count),   32'(m_retries));
         chk("model.lock_loss_cnt", 32'(bus.lock_loss_cnt), 32'(LL_ON ? m_losses : 0));
      end
   end

   typedef struct {
      bit locked; bit relock; int n;
      bit e_pll_rst; bit e_sys_rst; bit e_ready; bit e_fault; int e_retry; int e_loss;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(bit l, bit r, int n, bit p, bit s, bit rd, bit f, int rc, int ll);
      vec_t v;
      v.locked = l; v.relock = r; v.n = n;
      v.e_pll_rst = p; v.e_sys_rst = s; v.e_ready = rd; v.e_fault = f; v.e_retry = rc; v.e_loss = ll;
      return v;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge refclk);
      @(negedge refclk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.pll_locked = 1'b0;
      bus.relock_req = 1'b0;
      repeat (2) @(posedge refclk);
      @(negedge refclk);
      rst = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".pll_rst"}, 32'(bus.pll_rst), 32'd1);
      chk({tag, ".sys_rst"}, 32'(bus.sys_rst), 32'd1);
      chk({tag, ".ready"},   32'(bus.ready),   32'd0);
      chk({tag, ".fault"},   32'(bus.fault),   32'd0);
      chk({tag, ".retry_count"},   32'(bus.retry_count),   32'd0);
      chk({tag, ".lock_loss_cnt"}, 32'(bus.lock_loss_cnt), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ll;
      ll = LL_ON;
      bus.pll_locked = 1'b0;
      bus.relock_req = 1'b0;

      // No lock -> retries -> FAULT, relock, normal lock, loss in RUN, relock in RUN, qualify glitch
      tbl.push_back(mk(0,0, 3, 1,1,0,0, 0,0));
      tbl.push_back(mk(0,0, 1, 0,1,0,0, 0,0));
      tbl.push_back(mk(0,0,19, 0,1,0,0, 0,0));
      tbl.push_back(mk(0,0, 1, 1,1,0,0, 1,0));
      tbl.push_back(mk(0,0, 4, 0,1,0,0, 1,0));
      tbl.push_back(mk(0,0,20, 1,1,0,0, 2,0));
      tbl.push_back(mk(0,0,23, 0,1,0,0, 2,0));
      tbl.push_back(mk(0,0, 1, 1,1,0,1, 2,0));
      tbl.push_back(mk(0,0,10, 1,1,0,1, 2,0));
      tbl.push_back(mk(0,1, 1, 1,1,0,0, 0,0));
      tbl.push_back(mk(0,0, 3, 1,1,0,0, 0,0));
      tbl.push_back(mk(0,0, 1, 0,1,0,0, 0,0));
      tbl.push_back(mk(1,0,10, 0,1,0,0, 0,0));
      tbl.push_back(mk(1,0, 1, 0,0,1,0, 0,0));
      tbl.push_back(mk(0,0, 1, 0,0,1,0, 0,0));
      tbl.push_back(mk(0,0, 1, 0,0,1,0, 0,0));
      tbl.push_back(mk(0,0, 1, 1,1,0,0, 0,ll));
      tbl.push_back(mk(1,0,12, 0,1,0,0, 0,ll));
      tbl.push_back(mk(1,0, 1, 0,0,1,0, 0,ll));
      tbl.push_back(mk(1,1, 1, 1,1,0,0, 0,ll));
      tbl.push_back(mk(1,0, 4, 0,1,0,0, 0,ll));
      tbl.push_back(mk(1,0, 5, 0,1,0,0, 0,ll));
      tbl.push_back(mk(0,0, 2, 0,1,0,0, 0,ll));
      tbl.push_back(mk(0,0, 1, 1,1,0,0, 1,ll));
      tbl.push_back(mk(1,0, 3, 1,1,0,0, 1,ll));
      tbl.push_back(mk(1,0, 1, 0,1,0,0, 1,ll));
      tbl.push_back(mk(1,0, 8, 0,1,0,0, 1,ll));
      tbl.push_back(mk(1,0, 1, 0,0,1,0, 0,ll));

      do_reset();
      chk_reset_vals("reset");
      for (int i = 0; i < tbl.size(); i++) begin
         bus.pll_locked = tbl[i].locked;
         bus.relock_req = tbl[i].relock;
         step(tbl[i].n);
         chk($sformatf("tbl[%0d].pll_rst", i), 32'(bus.pll_rst), 32'(tbl[i].e_pll_rst));
         chk($sformatf("tbl[%0d].sys_rst", i), 32'(bus.sys_rst), 32'(tbl[i].e_sys_rst));
         chk($sformatf("tbl[%0d].ready", i),   32'(bus.ready),   32'(tbl[i].e_ready));
         chk($sformatf("tbl[%0d].fault", i),   32'(bus.fault),   32'(tbl[i].e_fault));
         chk($sformatf("tbl[%0d].retry_count", i),   32'(bus.retry_count),   32'(tbl[i].e_retry));
         chk($sformatf("tbl[%0d].lock_loss_cnt", i), 32'(bus.lock_loss_cnt), 32'(tbl[i].e_loss));
      end
      bus.relock_req = 1'b0;

      // Lock arriving exactly on the timeout edge wins over the retry
      do_reset();
      step(21);
      bus.pll_locked = 1'b1;
      step(3);
      chk("timeout_prio.retry_count", 32'(bus.retry_count), 32'd0);
      chk("timeout_prio.pll_rst",     32'(bus.pll_rst),     32'd0);
      step(8);
      chk("timeout_prio.ready",       32'(bus.ready),       32'd1);

      // Asynchronous reset mid-QUALIFY, between edges
      do_reset();
      bus.pll_locked = 1'b1;
      step(7);
      #2 rst = 1'b1;
      #1 chk_reset_vals("async_rst");
      #1 rst = 1'b0;
      repeat (3) @(posedge refclk);
      @(negedge refclk);
      chk("async_rst.pll_rst_held", 32'(bus.pll_rst), 32'd1);
      step(1);
      chk("async_rst.pll_rst_drop", 32'(bus.pll_rst), 32'd0);

      // Lock-loss counter saturation over 260 losses
      do_reset();
      for (int i = 0; i < 260; i++) begin
         bus.pll_locked = 1'b1;
         step(15);
         bus.pll_locked = 1'b0;
         step(2);
      end
      step(1);
      chk("loss_sat.lock_loss_cnt", 32'(bus.lock_loss_cnt), 32'(LL_ON ? 255 : 0));

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) bus.pll_locked = ~bus.pll_locked;
         bus.relock_req = ($urandom_range(0, 49) == 0);
         step(1);
      end
      bus.relock_req = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
